// File: rtl/ras_commit_shadow.sv
// rtl/ras_commit_shadow.sv - retire-side return address stack with recovery streaming
//
// Purpose: architectural RAS updated only by retired calls/returns. On a
// recovery request it snapshots the committed stack and streams it, oldest
// to youngest, over a valid/ready channel so fetch can rebuild its RAS.
//
// Optional debug ports: define RAS_COMMIT_SHADOW_DEBUG_EN.
//
// Ports:
//   clock, reset_n                      clock, synchronous active-low reset
//   retire_call, retire_return, retire_pc  retire-side stack updates
//   recover_req                         pulse: snapshot and stream the stack
//   rec_ready / rec_valid, rec_data, rec_idx, rec_last  recovery stream
//   rec_done, rec_busy                  recovery completion / in-progress
//   arch_top, arch_count                committed top-of-stack and occupancy
//   dbg_stack, dbg_head, dbg_tail, dbg_state  (debug build only)

module ras_commit_shadow #(
  parameter int RAS_SIZE = 8,
  parameter int PC_W     = 32
) (
  input  logic                          clock,
  input  logic                          reset_n,
  input  logic                          retire_call,
  input  logic                          retire_return,
  input  logic [PC_W-1:0]               retire_pc,
  input  logic                          recover_req,
  input  logic                          rec_ready,
  output logic                          rec_valid,
  output logic [PC_W-1:0]               rec_data,
  output logic [$clog2(RAS_SIZE)-1:0]   rec_idx,
  output logic                          rec_last,
  output logic                          rec_done,
  output logic                          rec_busy,
  output logic [PC_W-1:0]               arch_top,
  output logic [$clog2(RAS_SIZE+1)-1:0] arch_count
`ifdef RAS_COMMIT_SHADOW_DEBUG_EN
  ,
  output logic [RAS_SIZE-1:0][PC_W-1:0] dbg_stack,
  output logic [$clog2(RAS_SIZE)-1:0]   dbg_head,
  output logic [$clog2(RAS_SIZE)-1:0]   dbg_tail,
  output logic [1:0]                    dbg_state
`endif
);

  localparam int IW = $clog2(RAS_SIZE);
  localparam int CW = $clog2(RAS_SIZE + 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_STREAM = 2'd1,
    S_DONE   = 2'd2
  } state_e;

  logic [PC_W-1:0] stack_q [RAS_SIZE];
  logic [PC_W-1:0] stack_d [RAS_SIZE];
  logic [IW-1:0]   head_q, head_d;
  logic [IW-1:0]   tail_q, tail_d;
  logic [CW-1:0]   count_q, count_d;

  logic [PC_W-1:0] snap_q [RAS_SIZE];
  logic [IW-1:0]   snap_head_q;
  logic [CW-1:0]   snap_count_q;

  state_e          state_q, state_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic            snap_take;
  logic            last_w;
  logic [IW-1:0]   rd_ptr;
  logic [PC_W-1:0] pc4;

  // Live stack next state. Call+return on a non-empty stack replaces the top
  // in place; on an empty stack it degenerates to a plain call.
  always_comb begin
    stack_d = stack_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    pc4     = retire_pc + PC_W'(4);
    if (retire_call && retire_return && count_q != '0) begin
      stack_d[tail_q - IW'(1)] = pc4;
    end else if (retire_call) begin
      stack_d[tail_q] = pc4;
      tail_d          = tail_q + IW'(1);
      if (count_q == CW'(RAS_SIZE)) begin
        head_d = head_q + IW'(1);  // full: oldest entry is overwritten
      end else begin
        count_d = count_q + CW'(1);
      end
    end else if (retire_return && count_q != '0) begin
      tail_d  = tail_q - IW'(1);
      count_d = count_q - CW'(1);
    end
  end

  assign last_w = (CW'(idx_q) == snap_count_q - CW'(1));
  assign rd_ptr = snap_head_q + idx_q;

  // Recovery FSM. A new request always wins, restarting from a fresh
  // snapshot that already reflects this cycle's retire update.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    snap_take = 1'b0;
    if (recover_req) begin
      snap_take = 1'b1;
      idx_d     = '0;
      state_d   = (count_d != '0) ? S_STREAM : S_DONE;
    end else begin
      case (state_q)
        S_STREAM: begin
          if (rec_ready) begin
            if (last_w) state_d = S_DONE;
            else        idx_d   = idx_q + IW'(1);
          end
        end
        S_DONE:  state_d = S_IDLE;
        default: state_d = state_q;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      for (int k = 0; k < RAS_SIZE; k++) begin
        stack_q[k] <= '0;
        snap_q[k]  <= '0;
      end
      head_q       <= '0;
      tail_q       <= '0;
      count_q      <= '0;
      snap_head_q  <= '0;
      snap_count_q <= '0;
      idx_q        <= '0;
      state_q      <= S_IDLE;
    end else begin
      stack_q <= stack_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      idx_q   <= idx_d;
      state_q <= state_d;
      if (snap_take) begin
        snap_q       <= stack_d;
        snap_head_q  <= head_d;
        snap_count_q <= count_d;
      end
    end
  end

  assign rec_valid  = (state_q == S_STREAM);
  assign rec_busy   = (state_q != S_IDLE);
  assign rec_done   = (state_q == S_DONE);
  assign rec_idx    = idx_q;
  assign rec_last   = rec_valid && last_w;
  assign rec_data   = rec_valid ? snap_q[rd_ptr] : '0;
  assign arch_top   = stack_q[tail_q - IW'(1)];
  assign arch_count = count_q;

`ifdef RAS_COMMIT_SHADOW_DEBUG_EN
  always_comb begin
    for (int k = 0; k < RAS_SIZE; k++) dbg_stack[k] = stack_q[k];
  end
  assign dbg_head  = head_q;
  assign dbg_tail  = tail_q;
  assign dbg_state = state_q;
`endif

endmodule

// File: tb/tb_ras_commit_shadow.sv
// tb/tb_ras_commit_shadow.sv - self-checking bench for ras_commit_shadow
module tb_ras_commit_shadow;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        retire_call, retire_return, recover_req, rec_ready;
  logic [31:0] retire_pc;
  logic        rec_valid, rec_last, rec_done, rec_busy;
  logic [31:0] rec_data, arch_top;
  logic [2:0]  rec_idx;
  logic [3:0]  arch_count;

  ras_commit_shadow #(.RAS_SIZE(8), .PC_W(32)) dut (
    .clock(clock), .reset_n(reset_n),
    .retire_call(retire_call), .retire_return(retire_return), .retire_pc(retire_pc),
    .recover_req(recover_req), .rec_ready(rec_ready),
    .rec_valid(rec_valid), .rec_data(rec_data), .rec_idx(rec_idx), .rec_last(rec_last),
    .rec_done(rec_done), .rec_busy(rec_busy),
    .arch_top(arch_top), .arch_count(arch_count)
  );

  always #5 clock = ~clock;

  int tests = 0;
  int fails = 0;
  int done_seen = 0;

  // Reference: committed stack as a queue (front = oldest), the snapshot
  // being streamed, position in it, and mode 0=idle 1=streaming 2=done.
  logic [31:0] q[$];
  logic [31:0] snap[$];
  int pos = 0;
  int mode = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("arch_count", 64'(arch_count), 64'(q.size()));
    if (q.size() > 0) chk("arch_top", 64'(arch_top), 64'(q[$]));
    chk("rec_valid", 64'(rec_valid), 64'(mode == 1));
    chk("rec_busy", 64'(rec_busy), 64'(mode != 0));
    chk("rec_done", 64'(rec_done), 64'(mode == 2));
    if (mode == 1) begin
      chk("rec_data", 64'(rec_data), 64'(snap[pos]));
      chk("rec_idx", 64'(rec_idx), 64'(pos));
      chk("rec_last", 64'(rec_last), 64'(pos == snap.size() - 1));
    end
    if (rec_done === 1'b1) done_seen++;
  endtask

  task automatic cyc(input bit rn, input bit c, input bit r, input logic [31:0] pc,
                     input bit rq, input bit rd);
    logic [31:0] pc4;
    reset_n = rn; retire_call = c; retire_return = r; retire_pc = pc;
    recover_req = rq; rec_ready = rd;
    @(posedge clock);
    if (!rn) begin
      q.delete(); snap.delete(); mode = 0; pos = 0;
    end else begin
      pc4 = pc + 32'd4;
      if (c && r && q.size() > 0) q[q.size() - 1] = pc4;
      else if (c) begin
        q.push_back(pc4);
        if (q.size() > 8) void'(q.pop_front());
      end else if (r && q.size() > 0) void'(q.pop_back());
      if (rq) begin
        snap = q; pos = 0; mode = (snap.size() > 0) ? 1 : 2;
      end else if (mode == 1) begin
        if (rd) begin
          if (pos == snap.size() - 1) mode = 2;
          else pos++;
        end
      end else if (mode == 2) mode = 0;
    end
    #1;
    check_all();
  endtask

  task automatic idle(input bit rd);
    cyc(1, 0, 0, 32'h0, 0, rd);
  endtask

  int d0;

  initial begin
    cyc(0, 0, 0, 0, 0, 0);
    cyc(0, 1, 0, 32'h40, 1, 1);
    chk("rst_rec_data", 64'(rec_data), 64'h0);
    chk("rst_rec_idx", 64'(rec_idx), 64'h0);
    chk("rst_rec_last", 64'(rec_last), 64'h0);
    chk("rst_arch_top", 64'(arch_top), 64'h0);
    done_seen = 0;

    // push/pop and underflow
    cyc(1, 1, 0, 32'h100, 0, 0);
    cyc(1, 1, 0, 32'h200, 0, 0);
    cyc(1, 1, 0, 32'h300, 0, 0);
    chk("push_top", 64'(arch_top), 64'h304);
    cyc(1, 0, 1, 32'h0, 0, 0);
    chk("pop_top", 64'(arch_top), 64'h204);
    for (int k = 0; k < 3; k++) cyc(1, 0, 1, 32'h0, 0, 0);
    chk("underflow_count", 64'(arch_count), 64'h0);

    // overflow then full stream with rec_ready held high
    for (int k = 0; k < 10; k++) cyc(1, 1, 0, 32'h1000 + 32'(k) * 32'h10, 0, 0);
    chk("ovf_count", 64'(arch_count), 64'd8);
    d0 = done_seen;
    cyc(1, 0, 0, 0, 1, 1);
    chk("ovf_first", 64'(rec_data), 64'h1024);
    for (int k = 0; k < 7; k++) idle(1);
    chk("ovf_last_data", 64'(rec_data), 64'h1094);
    chk("ovf_last_flag", 64'(rec_last), 64'h1);
    idle(1);
    chk("ovf_done", 64'(rec_done), 64'h1);
    idle(1);
    chk("ovf_done_cnt", 64'(done_seen - d0), 64'd1);

    // backpressure with 3 entries: ready 1,0,0,1,1
    for (int k = 0; k < 5; k++) cyc(1, 0, 1, 0, 0, 0);
    chk("bp_count", 64'(arch_count), 64'd3);
    d0 = done_seen;
    cyc(1, 0, 0, 0, 1, 0);
    idle(1); idle(0); idle(0); idle(1); idle(1);
    chk("bp_done", 64'(rec_done), 64'h1);
    idle(0);
    chk("bp_done_cnt", 64'(done_seen - d0), 64'd1);

    // simultaneous call+return, then call with recover_req
    for (int k = 0; k < 1; k++) cyc(1, 0, 1, 0, 0, 0);
    cyc(1, 1, 1, 32'h500, 0, 0);
    chk("cr_top", 64'(arch_top), 64'h504);
    chk("cr_count", 64'(arch_count), 64'd2);
    cyc(1, 1, 0, 32'h600, 1, 0);
    chk("snap_count", 64'(snap.size()), 64'd3);
    idle(1); idle(1);
    chk("snap_last", 64'(rec_data), 64'h604);

    // restart after one accept; only one done overall
    idle(1); idle(0);
    d0 = done_seen;
    cyc(1, 0, 0, 0, 1, 1);
    idle(1);
    cyc(1, 0, 0, 0, 1, 1);
    chk("restart_idx", 64'(rec_idx), 64'd0);
    for (int k = 0; k < 4; k++) idle(1);
    chk("restart_done_cnt", 64'(done_seen - d0), 64'd1);

    // empty recovery
    for (int k = 0; k < 3; k++) cyc(1, 0, 1, 0, 0, 0);
    cyc(1, 0, 0, 0, 1, 1);
    chk("empty_valid", 64'(rec_valid), 64'h0);
    chk("empty_done", 64'(rec_done), 64'h1);
    idle(1);

    // reset mid-stream
    cyc(1, 1, 0, 32'h700, 0, 0);
    cyc(1, 1, 0, 32'h710, 1, 0);
    d0 = done_seen;
    cyc(0, 0, 0, 0, 0, 1);
    chk("rst_mid_valid", 64'(rec_valid), 64'h0);
    chk("rst_mid_busy", 64'(rec_busy), 64'h0);
    chk("rst_mid_count", 64'(arch_count), 64'h0);
    idle(1); idle(1);
    chk("rst_mid_nodone", 64'(done_seen - d0), 64'd0);

    // randomized traffic against the queue model
    for (int n = 0; n < 600; n++) begin
      cyc(($urandom_range(0, 199) != 0), ($urandom_range(0, 2) == 0),
          ($urandom_range(0, 3) == 0), $urandom, ($urandom_range(0, 24) == 0),
          ($urandom_range(0, 2) != 0));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/ras_commit_shadow.md
Name: ras_commit_shadow

Overview:
- Architectural (retire-side) return address stack that mirrors the speculative fetch-side RAS, but is updated only by retired calls and returns.
- On a branch-mispredict recovery request, it streams its committed contents, oldest to youngest, over a valid/ready channel so fetch can rebuild its speculative RAS.
- Sits between the retire stage and the fetch-side RAS.

Parameters:
- RAS_SIZE, 8, number of stack entries; must be a power of two ≥ 2.
- PC_W, 32, return address width in bits.

Ports:
- clock  in  1  system clock; all state updates on the rising edge.
- reset_n  in  1  synchronous active-low reset; sampled on the rising edge of clock.
- retire_call  in  1  a call instruction retires this cycle.
- retire_return  in  1  a return instruction retires this cycle.
- retire_pc  in  PC_W  PC of the retiring call/return.
- recover_req  in  1  single-cycle pulse: mispredict flush, rebuild the fetch RAS.
- rec_ready  in  1  fetch RAS can accept a recovery entry.
- rec_valid  out  1  recovery entry valid.
- rec_data  out  PC_W  recovery entry return address.
- rec_idx  out  $clog2(RAS_SIZE)  position of the entry; 0 = oldest.
- rec_last  out  1  current entry is the youngest (top).
- rec_done  out  1  one-cycle pulse when recovery completes.
- rec_busy  out  1  recovery in progress (STREAM or DONE).
- arch_top  out  PC_W  committed top-of-stack; don't-care when arch_count == 0.
- arch_count  out  $clog2(RAS_SIZE+1)  committed occupancy, 0..RAS_SIZE.

Behaviour:
- Storage: circular array with head (oldest) pointer, tail (next free) pointer and count. Pointers wrap modulo RAS_SIZE.
- Update rules (applied every cycle, independent of FSM state):
  - call only: stack[tail] = retire_pc+4; tail+1. If count == RAS_SIZE, head+1 (oldest overwritten, count stays RAS_SIZE); else count+1.
  - return only: if count > 0, tail-1 and count-1. If count == 0, no change.
  - call and return together: stack[tail-1] = retire_pc+4; pointers and count unchanged. If count == 0, treat as call only.
  - retire_pc+4 is computed modulo 2^PC_W, so wrap is silent.
- Recovery FSM states: IDLE, STREAM, DONE.
  - IDLE, recover_req=1: capture a snapshot of stack, head and count. The snapshot uses the next-state values, so it includes any same-cycle retire update. Set i=0. Go to STREAM if the snapshot count > 0, else DONE.
  - STREAM:
    - rec_valid=1, rec_data=snap[(snap_head+i) mod RAS_SIZE], rec_idx=i, rec_last=(i == snap_count-1).
    - On rec_valid & rec_ready: if rec_last, go to DONE; else i+1.
    - rec_data, rec_idx and rec_last stay stable while rec_ready=0.
  - DONE: rec_done=1 for exactly one cycle, then IDLE.
  - recover_req in STREAM or DONE: re-snapshot, i=0, and restart STREAM (or go to DONE if empty). The newer mispredict supersedes the older one, and no rec_done pulse is issued for the aborted stream.
- Retire updates during STREAM modify only the live stack, never the snapshot.
- rec_busy=1 in STREAM and DONE.
- Outputs are registered state or a combinational decode of registered state. There is no combinational path from rec_ready to rec_valid.
- Reset (reset_n=0 at a clock edge): all entries, snapshot, head, tail, count and i return to 0; FSM goes to IDLE.
  - Reset values: rec_valid=0, rec_done=0, rec_busy=0, rec_last=0, rec_idx=0, rec_data=0, arch_count=0, arch_top=0.
  - Reset mid-STREAM aborts without a rec_done pulse.
  - Reset has priority over all other inputs.

Optional Feature:
- Macro: RAS_COMMIT_SHADOW_DEBUG_EN.
- When defined, adds outputs:
  - dbg_stack (RAS_SIZE×PC_W), the live stack array.
  - dbg_head and dbg_tail ($clog2(RAS_SIZE) each).
  - dbg_state (2 bits: IDLE=0, STREAM=1, DONE=2).
- When undefined, these ports and their logic are absent; functional behaviour is identical.

Test Plan:
- Push/pop: calls at pc 0x100, 0x200, 0x300 -> arch_count=3, arch_top=0x304. One return -> arch_count=2, arch_top=0x204. Three more returns -> arch_count=0, no underflow.
- Overflow: RAS_SIZE=8, 10 calls at pc 0x1000+0x10·k (k=0..9) -> arch_count=8. recover_req with rec_ready=1 streams 0x1024, 0x1034, …, 0x1094 with rec_idx 0..7 and rec_last on idx 7; rec_done one cycle after the last accept.
- Backpressure: count=3. Recovery with rec_ready toggling 1,0,0,1,1 -> each entry is held stable while stalled and accepted exactly once; rec_done follows the third accept.
- Simultaneous events: call+return at pc 0x500 with count=2 -> top=0x504, count=2. A call at 0x600 in the same cycle as recover_req -> snapshot count=3, last entry 0x604.
- Restart: recover_req again after 1 accepted entry -> rec_idx restarts at 0, and only one rec_done is issued.
- Empty and reset: recover_req with count=0 -> rec_valid stays 0 and rec_done pulses the next cycle. reset_n=0 mid-STREAM -> next cycle rec_valid=0, rec_busy=0, arch_count=0, no rec_done.
